// File: rtl/phase_tracker.sv
// Receiver for the three-phase X/Y/Z machine-cycle strobes. It checks the order and spacing
// of the strobes, reports the current phase and lock status, latches a sticky fault code and
// counts completed triples.
module phase_tracker #(
    parameter int LOCK_TRIPLES = 2,
    parameter int MAX_GAP      = 4,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                   i_CLOCK,
    input  logic                   i_RESET_N,
    input  logic                   i_CYCLEX,
    input  logic                   i_CYCLEY,
    input  logic                   i_CYCLEZ,
    input  logic                   i_CLEAR_FAULT,
    output logic [1:0]             o_PHASE,
    output logic                   o_LOCKED,
    output logic                   o_FAULT,
    output logic [1:0]             o_FAULT_CODE,
    output logic                   o_TRIPLE_DONE,
    output logic [COUNT_WIDTH-1:0] o_TRIPLE_COUNT,
    output logic [1:0]             o_STATE
);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        EXP_Y = 2'd1,
        EXP_Z = 2'd2,
        EXP_X = 2'd3
    } state_t;

    localparam int GAP_W   = $clog2(MAX_GAP + 2);
    localparam int CLEAN_W = $clog2(LOCK_TRIPLES + 1);
    localparam logic [GAP_W-1:0]   GAP_LIMIT    = GAP_W'(MAX_GAP);
    localparam logic [GAP_W-1:0]   GAP_SAT      = GAP_W'(MAX_GAP + 1);
    localparam logic [CLEAN_W-1:0] CLEAN_TARGET = CLEAN_W'(LOCK_TRIPLES);

    localparam logic [1:0] FAULT_MULTI = 2'd1;
    localparam logic [1:0] FAULT_ORDER = 2'd2;
    localparam logic [1:0] FAULT_GAP   = 2'd3;

    state_t             state, state_next;
    logic [GAP_W-1:0]   gap_cnt, gap_next;
    logic [CLEAN_W-1:0] clean_cnt;
    logic [1:0]         phase_next;
    logic [2:0]         strobe_vec, exp_vec;
    logic [1:0]         strobe_cnt;
    logic               fault_hit;
    logic [1:0]         fault_kind;
    logic               triple_hit;

    assign strobe_vec = {i_CYCLEX, i_CYCLEY, i_CYCLEZ};
    assign strobe_cnt = {1'b0, i_CYCLEX} + {1'b0, i_CYCLEY} + {1'b0, i_CYCLEZ};
    assign o_STATE    = state;

    always_comb begin
        state_next = state;
        phase_next = o_PHASE;
        gap_next   = gap_cnt;
        fault_hit  = 1'b0;
        fault_kind = 2'd0;
        triple_hit = 1'b0;
        exp_vec    = 3'b000;

        case (state)
            EXP_Y:   exp_vec = 3'b010;
            EXP_Z:   exp_vec = 3'b001;
            EXP_X:   exp_vec = 3'b100;
            default: exp_vec = 3'b000;
        endcase

        if (state == HUNT) begin
            // Only a lone X starts a sequence; lone Y or Z are ignored while hunting.
            gap_next = '0;
            if (strobe_cnt >= 2'd2) begin
                fault_hit  = 1'b1;
                fault_kind = FAULT_MULTI;
            end else if (i_CYCLEX) begin
                state_next = EXP_Y;
                phase_next = 2'd1;
            end
        end else begin
            if (strobe_cnt >= 2'd2) begin
                fault_hit  = 1'b1;
                fault_kind = FAULT_MULTI;
            end else if (strobe_cnt == 2'd0) begin
                // MAX_GAP idle cycles are legal; the next idle cycle is a timeout.
                if (gap_cnt == GAP_LIMIT) begin
                    fault_hit  = 1'b1;
                    fault_kind = FAULT_GAP;
                end else if (gap_cnt != GAP_SAT) begin
                    gap_next = gap_cnt + 1'b1;
                end
            end else if (strobe_vec == exp_vec) begin
                gap_next = '0;
                case (state)
                    EXP_Y: begin
                        state_next = EXP_Z;
                        phase_next = 2'd2;
                    end
                    EXP_Z: begin
                        state_next = EXP_X;
                        phase_next = 2'd3;
                        triple_hit = 1'b1;
                    end
                    default: begin
                        state_next = EXP_Y;
                        phase_next = 2'd1;
                    end
                endcase
            end else begin
                fault_hit  = 1'b1;
                fault_kind = FAULT_ORDER;
            end
        end

        if (fault_hit) begin
            state_next = HUNT;
            phase_next = 2'd0;
            gap_next   = '0;
        end
    end

    always_ff @(posedge i_CLOCK) begin
        if (!i_RESET_N) begin
            state          <= HUNT;
            gap_cnt        <= '0;
            clean_cnt      <= '0;
            o_PHASE        <= 2'd0;
            o_LOCKED       <= 1'b0;
            o_FAULT        <= 1'b0;
            o_FAULT_CODE   <= 2'd0;
            o_TRIPLE_DONE  <= 1'b0;
            o_TRIPLE_COUNT <= '0;
        end else begin
            state         <= state_next;
            gap_cnt       <= gap_next;
            o_PHASE       <= phase_next;
            o_TRIPLE_DONE <= triple_hit;
            if (triple_hit) begin
                o_TRIPLE_COUNT <= o_TRIPLE_COUNT + 1'b1;
            end

            if (fault_hit) begin
                clean_cnt <= '0;
                o_LOCKED  <= 1'b0;
            end else if (triple_hit) begin
                if (clean_cnt != CLEAN_TARGET) begin
                    clean_cnt <= clean_cnt + 1'b1;
                end
                if (clean_cnt >= CLEAN_TARGET - 1'b1) begin
                    o_LOCKED <= 1'b1;
                end
            end

            // A new fault beats a simultaneous clear; otherwise the first code is kept.
            if (fault_hit) begin
                o_FAULT <= 1'b1;
                if (!o_FAULT || i_CLEAR_FAULT) begin
                    o_FAULT_CODE <= fault_kind;
                end
            end else if (i_CLEAR_FAULT) begin
                o_FAULT      <= 1'b0;
                o_FAULT_CODE <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_phase_tracker.sv
// Directed bench for phase_tracker: a table of per-cycle vectors with hand-computed outputs,
// followed by a counter wrap sequence using a narrow triple counter.
module tb_phase_tracker;

    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          cx, cy, cz, clr;
    logic [1:0]    phase;
    logic          locked, fault, done;
    logic [1:0]    code;
    logic [CW-1:0] count;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;

    phase_tracker #(.LOCK_TRIPLES(2), .MAX_GAP(4), .COUNT_WIDTH(CW)) dut (
        .i_CLOCK        (clk),
        .i_RESET_N      (rst_n),
        .i_CYCLEX       (cx),
        .i_CYCLEY       (cy),
        .i_CYCLEZ       (cz),
        .i_CLEAR_FAULT  (clr),
        .o_PHASE        (phase),
        .o_LOCKED       (locked),
        .o_FAULT        (fault),
        .o_FAULT_CODE   (code),
        .o_TRIPLE_DONE  (done),
        .o_TRIPLE_COUNT (count),
        .o_STATE        (dbg_state)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst_n, x, y, z, clr;
        logic [1:0]    phase;
        logic          locked, fault;
        logic [1:0]    code;
        logic          done;
        logic [CW-1:0] count;
    } vec_t;

    vec_t vecs[$];
    logic [11:0] exp_q[$];

    task automatic add(input logic r, input logic x, input logic y, input logic z, input logic c,
                       input logic [1:0] ph, input logic lk, input logic ft,
                       input logic [1:0] cd, input logic dn, input logic [CW-1:0] ct);
        vec_t v;
        v.rst_n = r; v.x = x; v.y = y; v.z = z; v.clr = c;
        v.phase = ph; v.locked = lk; v.fault = ft; v.code = cd; v.done = dn; v.count = ct;
        vecs.push_back(v);
    endtask

    // driver: inputs change on the falling edge, outputs sampled 1 time unit after the rising edge
    task automatic drive(input logic r, input logic x, input logic y, input logic z, input logic c);
        @(negedge clk);
        rst_n = r; cx = x; cy = y; cz = z; clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual ph=%0d lk=%0d ft=%0d cd=%0d dn=%0d ct=%0d required ph=%0d lk=%0d ft=%0d cd=%0d dn=%0d ct=%0d",
                     name, act[11:10], act[9], act[8], act[7:6], act[5], act[3:0],
                     exp_v[11:10], exp_v[9], exp_v[8], exp_v[7:6], exp_v[5], exp_v[3:0]);
        end
    endtask

    function automatic logic [11:0] pack_dut();
        return {phase, locked, fault, code, done, 1'b0, count};
    endfunction

    initial begin
        rst_n = 1'b0; cx = 1'b0; cy = 1'b0; cz = 1'b0; clr = 1'b0;

        // reset with a strobe present: ignored
        add(0,1,0,0,0, 0,0,0,0,0,0);
        // three back-to-back triples, lock after the second
        add(1,1,0,0,0, 1,0,0,0,0,0);
        add(1,0,1,0,0, 2,0,0,0,0,0);
        add(1,0,0,1,0, 3,0,0,0,1,1);
        add(1,1,0,0,0, 1,0,0,0,0,1);
        add(1,0,1,0,0, 2,0,0,0,0,1);
        add(1,0,0,1,0, 3,1,0,0,1,2);
        add(1,1,0,0,0, 1,1,0,0,0,2);
        add(1,0,1,0,0, 2,1,0,0,0,2);
        add(1,0,0,1,0, 3,1,0,0,1,3);
        // X then Z: out-of-order fault, then re-lock with two clean triples
        add(1,1,0,0,0, 1,1,0,0,0,3);
        add(1,0,0,1,0, 0,0,1,2,0,3);
        add(1,1,0,0,0, 1,0,1,2,0,3);
        add(1,0,1,0,0, 2,0,1,2,0,3);
        add(1,0,0,1,0, 3,0,1,2,1,4);
        add(1,1,0,0,0, 1,0,1,2,0,4);
        add(1,0,1,0,0, 2,0,1,2,0,4);
        add(1,0,0,1,0, 3,1,1,2,1,5);
        // clear together with an accepted X
        add(1,1,0,0,1, 1,1,0,0,0,5);
        // four idle cycles then Y is legal
        add(1,0,0,0,0, 1,1,0,0,0,5);
        add(1,0,0,0,0, 1,1,0,0,0,5);
        add(1,0,0,0,0, 1,1,0,0,0,5);
        add(1,0,0,0,0, 1,1,0,0,0,5);
        add(1,0,1,0,0, 2,1,0,0,0,5);
        // five idle cycles: timeout on the fifth
        add(1,0,0,0,0, 2,1,0,0,0,5);
        add(1,0,0,0,0, 2,1,0,0,0,5);
        add(1,0,0,0,0, 2,1,0,0,0,5);
        add(1,0,0,0,0, 2,1,0,0,0,5);
        add(1,0,0,0,0, 0,0,1,3,0,5);
        add(1,0,0,0,1, 0,0,0,0,0,5);
        // multi-strobe fault, later order fault keeps first code, clear behaviours
        add(1,1,0,0,0, 1,0,0,0,0,5);
        add(1,0,1,0,0, 2,0,0,0,0,5);
        add(1,0,0,1,0, 3,0,0,0,1,6);
        add(1,1,1,0,0, 0,0,1,1,0,6);
        add(1,1,0,0,0, 1,0,1,1,0,6);
        add(1,0,0,1,0, 0,0,1,1,0,6);
        add(1,0,0,0,1, 0,0,0,0,0,6);
        add(1,0,1,0,1, 0,0,0,0,0,6);
        add(1,1,1,0,1, 0,0,1,1,0,6);
        add(1,0,0,0,1, 0,0,0,0,0,6);
        // reset mid-triple, then a lone Z in HUNT
        add(1,1,0,0,0, 1,0,0,0,0,6);
        add(1,0,1,0,0, 2,0,0,0,0,6);
        add(0,0,0,1,0, 0,0,0,0,0,0);
        add(1,0,0,1,0, 0,0,0,0,0,0);

        foreach (vecs[i]) begin
            exp_q.push_back({vecs[i].phase, vecs[i].locked, vecs[i].fault, vecs[i].code,
                             vecs[i].done, 1'b0, vecs[i].count});
        end

        for (int i = 0; i < vecs.size(); i++) begin
            logic [11:0] exp_v;
            drive(vecs[i].rst_n, vecs[i].x, vecs[i].y, vecs[i].z, vecs[i].clr);
            exp_v = exp_q.pop_front();
            check($sformatf("vec%0d", i), pack_dut(), exp_v);
        end

        // 17 back-to-back triples on a 4-bit counter: wraps to 1, no fault, lock held
        for (int t = 0; t < 17; t++) begin
            logic [CW-1:0] exp_cnt;
            exp_cnt = CW'(t + 1);
            drive(1, 1, 0, 0, 0);
            drive(1, 0, 1, 0, 0);
            drive(1, 0, 0, 1, 0);
            check($sformatf("wrap_triple%0d", t), pack_dut(),
                  {2'd3, (t >= 1) ? 1'b1 : 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, exp_cnt});
        end
        drive(1, 0, 0, 0, 0);
        check("wrap_final", pack_dut(), {2'd3, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'd1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/phase_tracker.md
# phase_tracker

Receiving end of the three-phase machine-cycle strobes (CYCLEX → CYCLEY → CYCLEZ) produced by the clock divider. It checks phase ordering and spacing, reports the current phase to the control unit, and declares lock after a configurable number of clean X-Y-Z triples. It flags protocol faults with a sticky code and counts completed machine cycles.

## Interface
- LOCK_TRIPLES, 2: consecutive clean triples required before o_LOCKED asserts (≥1)
- MAX_GAP, 4: maximum idle cycles allowed between successive accepted strobes (0 = strictly back-to-back)
- COUNT_WIDTH, 16: width of o_TRIPLE_COUNT
- i_CLOCK  in  1  single clock, all logic on rising edge
- i_RESET_N  in  1  synchronous, active-low reset
- i_CYCLEX  in  1  phase-X strobe, one-cycle, synchronous to i_CLOCK
- i_CYCLEY  in  1  phase-Y strobe
- i_CYCLEZ  in  1  phase-Z strobe
- i_CLEAR_FAULT  in  1  clears sticky fault state
- o_PHASE  out  2  0 = none/hunting, 1 = X, 2 = Y, 3 = Z (last accepted strobe)
- o_LOCKED  out  1  LOCK_TRIPLES clean triples seen since last fault/reset
- o_FAULT  out  1  sticky fault flag
- o_FAULT_CODE  out  2  first fault since clear: 1 = multiple strobes, 2 = out of order, 3 = gap timeout
- o_TRIPLE_DONE  out  1  one-cycle pulse per completed X-Y-Z triple
- o_TRIPLE_COUNT  out  COUNT_WIDTH  completed triples, wraps modulo 2^COUNT_WIDTH

## Operation
- States: HUNT, EXP_Y, EXP_Z, EXP_X.
- HUNT: lone X → EXP_Y, o_PHASE=1. Lone Y or lone Z is ignored without fault. Two or more strobes in one cycle → fault 1, stay in HUNT.
- EXP_Y/EXP_Z/EXP_X: exactly the expected strobe → accept, advance (EXP_Y→EXP_Z→EXP_X→EXP_Y), set o_PHASE, clear gap counter.
- Accepting Z in EXP_Z completes a triple: pulse o_TRIPLE_DONE, increment o_TRIPLE_COUNT, increment the clean-triple counter (saturating at LOCK_TRIPLES).
- Clean-triple counter reaches LOCK_TRIPLES → o_LOCKED=1.
- No strobe → gap counter increments and o_PHASE holds. When the counter reaches MAX_GAP+1 in any EXP_* state → fault 3.
- Multiple strobes in an EXP_* state → fault 1. A single wrong strobe → fault 2.
- Any fault: state → HUNT, o_PHASE=0, o_LOCKED=0, clean-triple counter=0, gap counter=0, o_FAULT=1.
  - o_FAULT_CODE loads only if o_FAULT was 0; the first fault wins.
  - The strobe that caused the fault is not accepted, even if it is an X.
- o_TRIPLE_COUNT is not cleared by faults, only by reset.
- i_CLEAR_FAULT clears o_FAULT and o_FAULT_CODE. If a fault occurs in the same cycle, the new fault sets flag and code; set wins over clear.
- Gap counter saturates at MAX_GAP+1 and does not wrap.

## Timing
- All outputs registered. A strobe sampled at edge k is reflected on all outputs after edge k; latency 1 cycle.
- o_LOCKED rises in the same cycle as the o_TRIPLE_DONE of the LOCK_TRIPLES-th clean triple.
- Back-to-back triples (X,Y,Z,X,Y,Z, no gaps): o_TRIPLE_DONE every 3rd cycle, never stretched.
- Timeout boundary: a strobe arriving after exactly MAX_GAP idle cycles is legal. The fault fires on the edge that samples the (MAX_GAP+1)-th idle cycle.
- Reset (i_RESET_N=0 at an edge), including mid-triple: state HUNT and all counters 0. Outputs after that edge: o_PHASE=0, o_LOCKED=0, o_FAULT=0, o_FAULT_CODE=0, o_TRIPLE_DONE=0, o_TRIPLE_COUNT=0. Strobes during reset are ignored.

## Test plan
- Reset, then 3 back-to-back triples, MAX_GAP=4, LOCK_TRIPLES=2 → o_PHASE 1,2,3 repeating; o_TRIPLE_DONE at cycles 3,6,9; o_LOCKED=1 after cycle 6; o_TRIPLE_COUNT=3; o_FAULT=0.
- Lock, then X followed by Z → fault 2 on Z edge: o_LOCKED=0, o_PHASE=0, o_FAULT_CODE=2. A subsequent X restarts the sequence, and two more clean triples re-lock.
- Lock, then X, 4 idle cycles, Y → no fault. Next gap of 5 idle cycles → fault 3 on the 5th idle edge.
- X and Y asserted together in EXP_X → fault 1. A later out-of-order fault leaves o_FAULT_CODE=1. i_CLEAR_FAULT → 0. i_CLEAR_FAULT together with a new Y-in-HUNT → no fault, since Y is ignored in HUNT.
- COUNT_WIDTH=4, run 17 triples → o_TRIPLE_COUNT wraps to 1 with no fault.
- Assert i_RESET_N=0 after X,Y of a triple → all outputs 0 next cycle. A following Z is ignored in HUNT with no fault.
